// File: rtl/force_pkg.sv
// force_pkg
// Shared types and defaults for the packed-port force driver.
//   cmd_op_e : command opcodes carried on the cmd_op port
//   state_e  : force FSM states (IDLE / HOLD / FORCED)
//   DEF_*    : default parameter values for the driver
package force_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_HOLD_MIN = 4;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_FORCE   = 2'b01,
    OP_RELEASE = 2'b10,
    OP_REL_ALL = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_FORCED = 2'b10
  } state_e;

endpackage

// File: rtl/force_edge_det.sv
// force_edge_det
// Registers the level control en and reports its rising/falling edges.
// en is assumed synchronous to clk, so no synchroniser is inserted.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   en    - level control
//   rise  - en & ~en_q (combinational)
//   fall  - ~en & en_q (combinational)
module force_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  logic en_q;

  // Previous-cycle copy of en used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en;
    end
  end

  assign rise = en & ~en_q;
  assign fall = ~en & en_q;

endmodule

// File: rtl/packed_force_driver.sv
// packed_force_driver
// Drives a WIDTH-bit packed port and owns its per-bit force/release state.
// Forces come from en rising edges (all bits to EDGE_FVAL) or FORCE commands
// (masked bits to cmd_data). Releases come from en falling edges, RELEASE /
// RELEASE_ALL commands, or a release deferred until a hold window expires.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   en                  - level control, rise = force all, fall = release all
//   cmd_valid/cmd_ready - command handshake
//   cmd_op/mask/data    - opcode, affected bits, force values
//   drv_in              - normal (unforced) driver value
//   bus_out             - forced ? fval : drv_in, per bit
//   forced              - registered per-bit force state
//   busy                - high while a force is being held
//   evt_force/evt_release - one-cycle pulses aligned with the state update
module packed_force_driver
  import force_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               HOLD_MIN  = DEF_HOLD_MIN,
  parameter logic [WIDTH-1:0] EDGE_FVAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] drv_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] forced,
  output logic             busy,
  output logic             evt_force,
  output logic             evt_release
);

  // Counter holds HOLD_MIN-1 down to 0, so HOLD lasts HOLD_MIN cycles.
  localparam int CW = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD = (HOLD_MIN > 0) ? CW'(HOLD_MIN - 1) : '0;

  logic rise, fall;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] forced_q, forced_d;
  logic [WIDTH-1:0] fval_q, fval_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             pend_rel_q, pend_rel_d;
  logic             evt_force_q, evt_force_d;
  logic             evt_release_q, evt_release_d;

  logic             do_force, do_release, cmd_accept;
  logic [WIDTH-1:0] force_mask, force_data, rel_mask;

  force_edge_det u_edge_det (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .rise (rise),
    .fall (fall)
  );

  assign cmd_ready   = (state_q != ST_HOLD) & ~rise & ~fall;
  assign cmd_accept  = cmd_valid & cmd_ready;
  assign bus_out     = (forced_q & fval_q) | (~forced_q & drv_in);
  assign forced      = forced_q;
  assign busy        = (state_q == ST_HOLD);
  assign evt_force   = evt_force_q;
  assign evt_release = evt_release_q;

  // Select exactly one action per cycle (rise > fall > hold expiry >
  // command), then apply the chosen force or release to the registers.
  always_comb begin
    state_d       = state_q;
    forced_d      = forced_q;
    fval_d        = fval_q;
    hold_cnt_d    = hold_cnt_q;
    pend_rel_d    = pend_rel_q;
    evt_force_d   = 1'b0;
    evt_release_d = 1'b0;
    do_force      = 1'b0;
    do_release    = 1'b0;
    force_mask    = '0;
    force_data    = '0;
    rel_mask      = '0;

    if (rise) begin
      do_force   = 1'b1;
      force_mask = '1;
      force_data = EDGE_FVAL;
    end else if (fall) begin
      // A fall inside an unexpired hold is only remembered; the hold keeps
      // counting and the release is applied when it runs out.
      if (state_q == ST_HOLD && hold_cnt_q != '0) begin
        pend_rel_d = 1'b1;
        hold_cnt_d = hold_cnt_q - CW'(1);
      end else begin
        do_release = 1'b1;
        rel_mask   = '1;
      end
    end else if (state_q == ST_HOLD) begin
      if (hold_cnt_q == '0) begin
        if (pend_rel_q) begin
          do_release = 1'b1;
          rel_mask   = '1;
        end else begin
          state_d = ST_FORCED;
        end
      end else begin
        hold_cnt_d = hold_cnt_q - CW'(1);
      end
    end else if (cmd_accept) begin
      case (cmd_op_e'(cmd_op))
        OP_FORCE: begin
          // An empty mask is accepted but changes nothing.
          if (|cmd_mask) begin
            do_force   = 1'b1;
            force_mask = cmd_mask;
            force_data = cmd_data;
          end
        end
        OP_RELEASE: begin
          do_release = 1'b1;
          rel_mask   = cmd_mask;
        end
        OP_REL_ALL: begin
          do_release = 1'b1;
          rel_mask   = '1;
        end
        default: begin
        end
      endcase
    end

    if (do_force) begin
      forced_d    = forced_q | force_mask;
      fval_d      = (fval_q & ~force_mask) | (force_data & force_mask);
      evt_force_d = 1'b1;
      pend_rel_d  = 1'b0;
      hold_cnt_d  = HOLD_RELOAD;
      state_d     = (HOLD_MIN == 0) ? ST_FORCED : ST_HOLD;
    end

    // fval is kept on release so a later partial force only rewrites its bits.
    if (do_release) begin
      forced_d      = forced_q & ~rel_mask;
      evt_release_d = |(forced_q & rel_mask);
      pend_rel_d    = 1'b0;
      hold_cnt_d    = '0;
      state_d       = (|forced_d) ? ST_FORCED : ST_IDLE;
    end
  end

  // State, mask and event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      forced_q      <= '0;
      fval_q        <= '0;
      hold_cnt_q    <= '0;
      pend_rel_q    <= 1'b0;
      evt_force_q   <= 1'b0;
      evt_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      forced_q      <= forced_d;
      fval_q        <= fval_d;
      hold_cnt_q    <= hold_cnt_d;
      pend_rel_q    <= pend_rel_d;
      evt_force_q   <= evt_force_d;
      evt_release_q <= evt_release_d;
    end
  end

endmodule
